// File: rtl/image_stage_sequencer.sv
// image_stage_sequencer
// Runs the selected image-processing stages one at a time, lowest index first,
// and routes the active stage's address, write data and write enable onto the
// single SRAM port. Between stages the block waits for the finished stage to
// drop its done flag before it enables the next one.
// Optional feature: define SEQ_WATCHDOG_EN to add a per-stage watchdog that
// forces a stuck stage to be skipped and raises a sticky timeout_error.
module image_stage_sequencer #(
  parameter int unsigned NUM_STAGES     = 4,
  parameter int unsigned ADDR_WIDTH     = 18,
  parameter int unsigned DATA_WIDTH     = 32,
  parameter int unsigned TIMEOUT_CYCLES = 32'h00FF_FFFF
) (
  input  logic                             clk_div_by_two,
  input  logic                             reset_n,
  input  logic                             start,
  input  logic                             abort,
  input  logic [NUM_STAGES-1:0]            stage_mask,
  output logic [NUM_STAGES-1:0]            stage_enable,
  input  logic [NUM_STAGES-1:0]            stage_done,
  input  logic [NUM_STAGES*ADDR_WIDTH-1:0] stage_address,
  input  logic [NUM_STAGES*DATA_WIDTH-1:0] stage_data_write,
  input  logic [NUM_STAGES-1:0]            stage_wren,
  output logic [ADDR_WIDTH-1:0]            sram_address,
  output logic [DATA_WIDTH-1:0]            sram_data_write,
  output logic                             sram_wren,
  output logic [2:0]                       current_stage,
  output logic                             busy,
  output logic                             pipeline_done,
  output logic                             timeout_error
);

  // Reject configurations the 3-bit stage index or 24-bit watchdog cannot hold.
  generate
    if (NUM_STAGES < 2 || NUM_STAGES > 8 ||
        TIMEOUT_CYCLES < 1 || TIMEOUT_CYCLES > 32'h00FF_FFFF) begin : g_param_check
      $error("image_stage_sequencer: parameter out of range");
    end
  endgenerate

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2,
    ST_DONE  = 2'd3
  } state_e;

  state_e                state_q, state_d;
  logic [NUM_STAGES-1:0] mask_q, mask_d;
  logic [2:0]            cur_q, cur_d;

  logic [NUM_STAGES-1:0] cur_onehot;
  logic                  cur_done;
  logic                  start_accept;
  logic                  wd_expired;
  logic [2:0]            first_idx;
  logic [2:0]            next_idx;
  logic                  next_found;

  // Decode the active slot index once; every per-slot select below uses it.
  genvar gi;
  generate
    for (gi = 0; gi < NUM_STAGES; gi++) begin : g_slot
      assign cur_onehot[gi]   = (cur_q == 3'(gi));
      assign stage_enable[gi] = (state_q == ST_RUN) && cur_onehot[gi];
    end
  endgenerate

  // Done flags of slots other than the active one never reach the FSM.
  assign cur_done     = |(stage_done & cur_onehot);
  assign start_accept = (state_q == ST_IDLE) && start && !abort;

  // Lowest set bit of the incoming mask, and the next latched bit above cur.
  always_comb begin
    first_idx  = 3'd0;
    next_idx   = 3'd0;
    next_found = 1'b0;
    for (int i = NUM_STAGES - 1; i >= 0; i--) begin
      if (stage_mask[i]) begin
        first_idx = 3'(i);
      end
      if (mask_q[i] && (3'(i) > cur_q)) begin
        next_idx   = 3'(i);
        next_found = 1'b1;
      end
    end
  end

  // Sequencing FSM next-state: abort overrides everything, including a start.
  always_comb begin
    state_d = state_q;
    mask_d  = mask_q;
    cur_d   = cur_q;
    if (abort) begin
      state_d = ST_IDLE;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (start_accept) begin
            mask_d = stage_mask;
            if (stage_mask == '0) begin
              state_d = ST_DONE;
            end else begin
              cur_d   = first_idx;
              state_d = ST_RUN;
            end
          end
        end
        ST_RUN: begin
          if (cur_done || wd_expired) begin
            state_d = ST_DRAIN;
          end
        end
        ST_DRAIN: begin
          // A stage only counts as finished once its done flag has dropped.
          if (!cur_done || wd_expired) begin
            if (next_found) begin
              cur_d   = next_idx;
              state_d = ST_RUN;
            end else begin
              state_d = ST_DONE;
            end
          end
        end
        ST_DONE: begin
          state_d = ST_IDLE;
        end
        default: begin
          state_d = ST_IDLE;
        end
      endcase
    end
  end

  // Sequencing FSM state register.
  always_ff @(posedge clk_div_by_two or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= ST_IDLE;
      mask_q  <= '0;
      cur_q   <= 3'd0;
    end else begin
      state_q <= state_d;
      mask_q  <= mask_d;
      cur_q   <= cur_d;
    end
  end

`ifdef SEQ_WATCHDOG_EN
  localparam logic [23:0] WD_LAST = 24'(TIMEOUT_CYCLES - 1);

  logic [23:0] wd_cnt_q, wd_cnt_d;
  logic        timeout_error_q, timeout_error_d;

  // The counter value equals the number of edges already spent in this state.
  assign wd_expired = ((state_q == ST_RUN) || (state_q == ST_DRAIN)) && (wd_cnt_q == WD_LAST);

  // Watchdog counter restarts on every state change; the error flag is sticky per run.
  always_comb begin
    wd_cnt_d        = wd_cnt_q;
    timeout_error_d = timeout_error_q;
    if (state_d != state_q) begin
      wd_cnt_d = '0;
    end else if ((state_q == ST_RUN) || (state_q == ST_DRAIN)) begin
      wd_cnt_d = wd_cnt_q + 24'd1;
    end
    if (start_accept) begin
      timeout_error_d = 1'b0;
    end else if (wd_expired && !abort) begin
      timeout_error_d = 1'b1;
    end
  end

  // Watchdog registers.
  always_ff @(posedge clk_div_by_two or negedge reset_n) begin
    if (!reset_n) begin
      wd_cnt_q        <= '0;
      timeout_error_q <= 1'b0;
    end else begin
      wd_cnt_q        <= wd_cnt_d;
      timeout_error_q <= timeout_error_d;
    end
  end

  assign timeout_error = timeout_error_q;
`else
  // Without the watchdog a silent stage stalls the run until abort or reset.
  assign wd_expired    = 1'b0;
  assign timeout_error = 1'b0;
`endif

  // Zero-latency SRAM mux; the port is driven to zero whenever no stage runs.
  always_comb begin
    sram_address    = '0;
    sram_data_write = '0;
    sram_wren       = 1'b0;
    if (state_q == ST_RUN) begin
      for (int i = 0; i < NUM_STAGES; i++) begin
        if (cur_onehot[i]) begin
          sram_address    = stage_address[i*ADDR_WIDTH +: ADDR_WIDTH];
          sram_data_write = stage_data_write[i*DATA_WIDTH +: DATA_WIDTH];
          sram_wren       = stage_wren[i];
        end
      end
    end
  end

  assign busy          = (state_q != ST_IDLE);
  assign pipeline_done = (state_q == ST_DONE);
  assign current_stage = ((state_q == ST_RUN) || (state_q == ST_DRAIN)) ? cur_q : 3'd0;

endmodule

// File: tb/tb_image_stage_sequencer.sv
// Self-checking bench for image_stage_sequencer: directed scenarios plus
// randomized runs, compared every cycle against a queue-based run model.
module tb_image_stage_sequencer;

  localparam int NS = 4;
  localparam int AW = 18;
  localparam int DW = 32;
  localparam int TO = 100;
`ifdef SEQ_WATCHDOG_EN
  localparam bit WD_ON = 1'b1;
`else
  localparam bit WD_ON = 1'b0;
`endif

  logic              clk_div_by_two = 1'b0;
  logic              reset_n;
  logic              start;
  logic              abort;
  logic [NS-1:0]     stage_mask;
  logic [NS-1:0]     stage_enable;
  logic [NS-1:0]     stage_done;
  logic [NS*AW-1:0]  stage_address;
  logic [NS*DW-1:0]  stage_data_write;
  logic [NS-1:0]     stage_wren;
  logic [AW-1:0]     sram_address;
  logic [DW-1:0]     sram_data_write;
  logic              sram_wren;
  logic [2:0]        current_stage;
  logic              busy;
  logic              pipeline_done;
  logic              timeout_error;

  always #5 clk_div_by_two = ~clk_div_by_two;

  image_stage_sequencer #(
    .NUM_STAGES(NS), .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .TIMEOUT_CYCLES(TO)
  ) dut (
    .clk_div_by_two  (clk_div_by_two),
    .reset_n         (reset_n),
    .start           (start),
    .abort           (abort),
    .stage_mask      (stage_mask),
    .stage_enable    (stage_enable),
    .stage_done      (stage_done),
    .stage_address   (stage_address),
    .stage_data_write(stage_data_write),
    .stage_wren      (stage_wren),
    .sram_address    (sram_address),
    .sram_data_write (sram_data_write),
    .sram_wren       (sram_wren),
    .current_stage   (current_stage),
    .busy            (busy),
    .pipeline_done   (pipeline_done),
    .timeout_error   (timeout_error)
  );

  int n_checks = 0;
  int n_errors = 0;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got=0x%0h expected=0x%0h at t=%0t", tag, got, exp, $time);
    end
  endtask

  // Run model: a queue of stages still to run plus the current phase.
  bit            m_running, m_drain, m_pd, m_terr;
  int            m_active;
  int            m_cnt;
  int            m_pending[$];
  logic [NS-1:0] m_mask;

  // Stage behaviour models and random SRAM traffic per slot.
  int            lat[NS];
  int            clr_delay[NS];
  int            en_cnt[NS];
  int            clr_cnt[NS];
  logic [AW-1:0] addr_a[NS];
  logic [DW-1:0] data_a[NS];
  logic          wren_a[NS];
  bit            fixed_slot1, noise_on;

  // Observations from the DUT.
  int            seen_q[$];
  int            pd_count;
  logic [NS-1:0] prev_en;

  task automatic model_reset();
    m_running = 0; m_drain = 0; m_pd = 0; m_terr = 0;
    m_active = -1; m_cnt = 0; m_mask = '0;
    m_pending.delete();
  endtask

  task automatic stage_reset();
    for (int i = 0; i < NS; i++) begin
      en_cnt[i] = 0; clr_cnt[i] = 0; lat[i] = 1; clr_delay[i] = 0;
      addr_a[i] = '0; data_a[i] = '0; wren_a[i] = 1'b0;
      stage_done[i] = 1'b0;
      stage_address[i*AW +: AW] = '0;
      stage_data_write[i*DW +: DW] = '0;
      stage_wren[i] = 1'b0;
    end
  endtask

  // Apply the inputs present at a rising edge to the run model.
  task automatic model_edge();
    bit to;
    if (abort) begin
      m_running = 0; m_pd = 0; m_drain = 0; m_active = -1;
      m_pending.delete();
      return;
    end
    if (!m_running) begin
      if (start) begin
        m_terr = 0;
        m_mask = stage_mask;
        m_pending.delete();
        for (int i = 0; i < NS; i++) if (stage_mask[i]) m_pending.push_back(i);
        m_running = 1; m_drain = 0; m_cnt = 0;
        if (m_pending.size() == 0) begin
          m_pd = 1; m_active = -1;
        end else begin
          m_active = m_pending.pop_front();
        end
      end
      return;
    end
    if (m_pd) begin
      m_pd = 0; m_running = 0;
      return;
    end
    m_cnt++;
    to = WD_ON && (m_cnt == TO);
    if (to) m_terr = 1;
    if (!m_drain) begin
      if (stage_done[m_active] || to) begin
        m_drain = 1; m_cnt = 0;
      end
    end else if (!stage_done[m_active] || to) begin
      m_drain = 0; m_cnt = 0;
      if (m_pending.size() > 0) m_active = m_pending.pop_front();
      else begin
        m_active = -1; m_pd = 1;
      end
    end
  endtask

  function automatic logic [NS-1:0] exp_enable();
    logic [NS-1:0] e;
    e = '0;
    if (m_running && m_active >= 0 && !m_drain) e[m_active] = 1'b1;
    return e;
  endfunction

  // Stage models react to the enable the model says they should see.
  task automatic stage_update();
    logic [NS-1:0] e;
    e = exp_enable();
    for (int i = 0; i < NS; i++) begin
      if (e[i]) begin
        en_cnt[i]++;
        if (en_cnt[i] >= lat[i] && !stage_done[i]) begin
          stage_done[i] = 1'b1;
          clr_cnt[i] = clr_delay[i];
        end
      end else begin
        en_cnt[i] = 0;
        if (noise_on && m_running && !m_mask[i]) begin
          stage_done[i] = 1'($urandom_range(0, 1));
        end else if (stage_done[i]) begin
          if (clr_cnt[i] == 0) stage_done[i] = 1'b0;
          else clr_cnt[i]--;
        end
      end
      addr_a[i] = AW'($urandom);
      data_a[i] = DW'($urandom);
      wren_a[i] = 1'($urandom_range(0, 1));
      if (fixed_slot1 && i == 1) begin
        addr_a[i] = 18'h12345;
        data_a[i] = 32'hDEADBEEF;
        wren_a[i] = 1'b1;
      end
      stage_address[i*AW +: AW]    = addr_a[i];
      stage_data_write[i*DW +: DW] = data_a[i];
      stage_wren[i]                = wren_a[i];
    end
  endtask

  task automatic compare_outputs();
    logic [NS-1:0] e_en;
    logic [AW-1:0] e_addr;
    logic [DW-1:0] e_data;
    logic          e_wren;
    int            e_cur;
    e_en = exp_enable();
    e_addr = '0; e_data = '0; e_wren = 1'b0; e_cur = 0;
    if (m_running && m_active >= 0) e_cur = m_active;
    if (e_en != '0) begin
      e_addr = addr_a[m_active];
      e_data = data_a[m_active];
      e_wren = wren_a[m_active];
    end
    check_eq("stage_enable", 64'(stage_enable), 64'(e_en));
    check_eq("busy", 64'(busy), 64'(m_running));
    check_eq("pipeline_done", 64'(pipeline_done), 64'(m_pd));
    check_eq("current_stage", 64'(current_stage), 64'(e_cur));
    check_eq("sram_address", 64'(sram_address), 64'(e_addr));
    check_eq("sram_data_write", 64'(sram_data_write), 64'(e_data));
    check_eq("sram_wren", 64'(sram_wren), 64'(e_wren));
    check_eq("timeout_error", 64'(timeout_error), 64'(m_terr));
    if (stage_enable != '0 && prev_en == '0) begin
      for (int i = 0; i < NS; i++) if (stage_enable[i]) seen_q.push_back(i);
    end
    if (pipeline_done) pd_count++;
    prev_en = stage_enable;
  endtask

  task automatic step();
    @(posedge clk_div_by_two);
    model_edge();
    #1;
    stage_update();
    #1;
    compare_outputs();
  endtask

  task automatic run_until_idle(input string tag, input int budget);
    int k;
    k = 0;
    while ((m_running || busy) && k < budget) begin
      step();
      k++;
    end
    check_eq({tag, "_idle"}, 64'(busy), 64'(0));
  endtask

  task automatic begin_run(input logic [NS-1:0] mask);
    seen_q.delete();
    pd_count = 0;
    stage_mask = mask;
    start = 1'b1;
    step();
    start = 1'b0;
    stage_mask = NS'($urandom);
  endtask

  initial begin
    bit mux_checked, drain_checked;
    int k;
    reset_n = 1'b0; start = 1'b0; abort = 1'b0; stage_mask = '0;
    fixed_slot1 = 0; noise_on = 0; prev_en = '0; pd_count = 0;
    model_reset();
    stage_reset();
    repeat (2) @(posedge clk_div_by_two);
    #2;
    check_eq("reset_enable", 64'(stage_enable), 64'(0));
    check_eq("reset_busy", 64'(busy), 64'(0));
    check_eq("reset_pd", 64'(pipeline_done), 64'(0));
    check_eq("reset_wren", 64'(sram_wren), 64'(0));
    check_eq("reset_cur", 64'(current_stage), 64'(0));
    reset_n = 1'b1;
    step();

    // Mask 1011 with 20-cycle stages and a fixed pattern on slot 1.
    for (int i = 0; i < NS; i++) begin lat[i] = 20; clr_delay[i] = 0; end
    fixed_slot1 = 1;
    mux_checked = 0; drain_checked = 0;
    begin_run(4'b1011);
    k = 0;
    while ((m_running || busy) && k < 500) begin
      step();
      k++;
      if (m_running && m_active == 1 && !m_drain && !mux_checked) begin
        check_eq("mux_addr", 64'(sram_address), 64'h12345);
        check_eq("mux_data", 64'(sram_data_write), 64'hDEADBEEF);
        check_eq("mux_wren", 64'(sram_wren), 64'(1));
        mux_checked = 1;
      end
      if (m_running && m_active == 1 && m_drain && !drain_checked) begin
        check_eq("drain_wren", 64'(sram_wren), 64'(0));
        check_eq("drain_enable", 64'(stage_enable), 64'(0));
        drain_checked = 1;
      end
    end
    check_eq("seq1011_idle", 64'(busy), 64'(0));
    check_eq("seq1011_count", 64'(seen_q.size()), 64'(3));
    if (seen_q.size() == 3) begin
      check_eq("seq1011_first", 64'(seen_q[0]), 64'(0));
      check_eq("seq1011_second", 64'(seen_q[1]), 64'(1));
      check_eq("seq1011_third", 64'(seen_q[2]), 64'(3));
    end
    check_eq("seq1011_pd", 64'(pd_count), 64'(1));
    check_eq("mux_reached", 64'(mux_checked && drain_checked), 64'(1));
    fixed_slot1 = 0;
    $display("run directed mask=1011 stages_seen=%0d pulses=%0d", seen_q.size(), pd_count);
    step();

    // Empty mask: one busy cycle carrying the done pulse.
    begin_run(4'b0000);
    check_eq("empty_busy", 64'(busy), 64'(1));
    check_eq("empty_pd", 64'(pipeline_done), 64'(1));
    check_eq("empty_enable", 64'(stage_enable), 64'(0));
    step();
    check_eq("empty_busy_fall", 64'(busy), 64'(0));
    check_eq("empty_pd_count", 64'(pd_count), 64'(1));
    $display("run directed mask=0000 pulses=%0d", pd_count);

    // Abort mid-run of stage 0 together with a repeated start.
    begin_run(4'b0011);
    repeat (5) step();
    abort = 1'b1; start = 1'b1; stage_mask = 4'b0011;
    step();
    abort = 1'b0; start = 1'b0;
    check_eq("abort_enable", 64'(stage_enable), 64'(0));
    check_eq("abort_busy", 64'(busy), 64'(0));
    repeat (25) step();
    check_eq("abort_no_pd", 64'(pd_count), 64'(0));
    check_eq("abort_stays_idle", 64'(busy), 64'(0));
    $display("run directed abort pulses=%0d", pd_count);

    // Asynchronous reset during stage 1, then a fresh run.
    for (int i = 0; i < NS; i++) begin lat[i] = 5; clr_delay[i] = 1; end
    begin_run(4'b0110);
    k = 0;
    while (!(m_running && m_active == 1 && !m_drain) && k < 100) begin
      step();
      k++;
    end
    check_eq("pre_reset_enable", 64'(stage_enable), 64'(4'b0010));
    reset_n = 1'b0;
    #1;
    check_eq("arst_enable", 64'(stage_enable), 64'(0));
    check_eq("arst_busy", 64'(busy), 64'(0));
    check_eq("arst_cur", 64'(current_stage), 64'(0));
    check_eq("arst_wren", 64'(sram_wren), 64'(0));
    check_eq("arst_addr", 64'(sram_address), 64'(0));
    check_eq("arst_data", 64'(sram_data_write), 64'(0));
    check_eq("arst_pd", 64'(pipeline_done), 64'(0));
    model_reset();
    stage_reset();
    for (int i = 0; i < NS; i++) begin lat[i] = 5; clr_delay[i] = 1; end
    prev_en = '0;
    repeat (2) @(posedge clk_div_by_two);
    #2;
    reset_n = 1'b1;
    begin_run(4'b0110);
    check_eq("restart_first", 64'(stage_enable), 64'(4'b0010));
    run_until_idle("restart", 300);
    $display("run directed reset-restart stages_seen=%0d pulses=%0d", seen_q.size(), pd_count);

`ifdef SEQ_WATCHDOG_EN
    // Stage 0 never finishes; the watchdog must skip it and let stage 1 run.
    lat[0] = 1000000; lat[1] = 3;
    begin_run(4'b0011);
    run_until_idle("wd_run", 600);
    check_eq("wd_timeout_set", 64'(timeout_error), 64'(1));
    check_eq("wd_pd", 64'(pd_count), 64'(1));
    check_eq("wd_seen", 64'(seen_q.size()), 64'(2));
    begin_run(4'b0010);
    check_eq("wd_cleared", 64'(timeout_error), 64'(0));
    run_until_idle("wd_rerun", 300);
    $display("run directed watchdog pulses=%0d", pd_count);
`endif

    // Randomized runs: random masks, latencies, start holds, aborts and noise.
    noise_on = 1;
    for (int run = 0; run < 20; run++) begin
      int hold, abort_at, used;
      for (int i = 0; i < NS; i++) begin
        lat[i] = $urandom_range(1, 8);
        clr_delay[i] = $urandom_range(0, 3);
      end
      hold = $urandom_range(1, 3);
      abort_at = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 30) : -1;
      seen_q.delete();
      pd_count = 0;
      stage_mask = NS'($urandom);
      start = 1'b1;
      used = 0;
      for (int c = 0; c < 600; c++) begin
        step();
        used = c + 1;
        if (c + 1 >= hold && !m_running && !busy) break;
        start = (c + 1 < hold);
        abort = (c + 1 == abort_at);
        stage_mask = NS'($urandom);
      end
      start = 1'b0;
      abort = 1'b0;
      check_eq("rand_idle", 64'(busy), 64'(0));
      $display("run random %0d cycles=%0d stages_seen=%0d pulses=%0d", run, used, seen_q.size(), pd_count);
      step();
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
